// File: rtl/usb_pkg.sv
// Shared request codes, descriptor types, handshake encodings and the EP0 state set
// for the endpoint-0 control-transfer engine.
package usb_pkg;

  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'd6;
  localparam logic [7:0] REQ_SET_ADDRESS       = 8'd5;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'd9;

  localparam logic [7:0] DESC_DEVICE = 8'd1;
  localparam logic [7:0] DESC_CONFIG = 8'd2;

  localparam logic [1:0] HS_ACK   = 2'b01;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_IN,
    ST_STATUS_OUT,
    ST_STATUS_IN,
    ST_STALL
  } ep0_state_e;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_desc_rom.sv
// Device and configuration descriptor ROM; one registered byte per read enable,
// held between reads so the IN byte stays stable until the next request.
module usb_desc_rom
  import usb_pkg::*;
(
  input  logic       clki,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       rd_en,
  input  logic [7:0] desc_type,
  input  logic [7:0] offset,
  output logic [7:0] data
);

  function automatic logic [7:0] rom_byte(input logic cfg, input logic [7:0] off);
    logic [7:0] b;
    b = 8'h00;
    if (!cfg) begin
      case (off)
        8'd0:  b = 8'h12;  8'd1:  b = 8'h01;  8'd2:  b = 8'h00;  8'd3:  b = 8'h02;
        8'd4:  b = 8'hFF;  8'd5:  b = 8'h00;  8'd6:  b = 8'h00;  8'd7:  b = 8'h40;
        8'd8:  b = 8'h09;  8'd9:  b = 8'h12;  8'd10: b = 8'hF0;  8'd11: b = 8'h5B;
        8'd12: b = 8'h01;  8'd13: b = 8'h00;  8'd14: b = 8'h00;  8'd15: b = 8'h00;
        8'd16: b = 8'h00;  8'd17: b = 8'h01;
        default: b = 8'h00;
      endcase
    end else begin
      // 9-byte configuration (wTotalLength 18, one interface) then a 9-byte interface with no endpoints
      case (off)
        8'd0:  b = 8'h09;  8'd1:  b = 8'h02;  8'd2:  b = 8'h12;  8'd3:  b = 8'h00;
        8'd4:  b = 8'h01;  8'd5:  b = 8'h01;  8'd6:  b = 8'h00;  8'd7:  b = 8'h80;
        8'd8:  b = 8'h32;  8'd9:  b = 8'h09;  8'd10: b = 8'h04;  8'd11: b = 8'h00;
        8'd12: b = 8'h00;  8'd13: b = 8'h00;  8'd14: b = 8'hFF;  8'd15: b = 8'h00;
        8'd16: b = 8'h00;  8'd17: b = 8'h00;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)     data <= 8'h00;
    else if (clr)   data <= 8'h00;
    else if (rd_en) data <= rom_byte(desc_type == DESC_CONFIG, offset);
  end

endmodule

// File: rtl/usb_ep0_ctrl.sv
// EP0 control-transfer engine: gathers the SETUP packet, decodes standard requests,
// streams descriptors and owns the device address / configuration value.
module usb_ep0_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_PACKET   = 64,
  parameter int DEV_DESC_LEN = 18,
  parameter int CFG_DESC_LEN = 18
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       usb_rst,
  input  logic       setup,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  input  logic       rx_done,
  input  logic       tx_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       in_done,
  output logic [1:0] handshake,
  output logic [6:0] usb_addr,
  output logic [7:0] cfg_value
);

  localparam int            PW      = $clog2(MAX_PACKET + 1);
  localparam logic [PW-1:0] PKT_MAX = PW'(MAX_PACKET);

  ep0_state_e    state, state_nxt, dec_state;
  logic [7:0]    setup_buf [8];
  logic [3:0]    byte_cnt;
  logic          vld_p1, dir_in_p1;
  logic [7:0]    req_p1;
  logic [15:0]   wvalue_p1, wlength_p1;
  logic [15:0]   remaining, dec_total;
  logic [7:0]    offset, desc_type;
  logic [PW-1:0] pkt_cnt;
  logic          zlp_pend, dec_zlp;
  logic          setup_byte, byte_ok;

  assign setup_byte = setup && rx_strobe;
  assign byte_ok    = (state == ST_DATA_IN) && (pkt_cnt < PKT_MAX) &&
                      (remaining != 16'd0) && !setup_byte;

  // p0: SETUP byte capture
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)                              byte_cnt <= 4'd0;
    else if (usb_rst || !setup || rx_done)   byte_cnt <= 4'd0;
    else if (rx_strobe && byte_cnt != 4'd8)  byte_cnt <= byte_cnt + 4'd1;
  end

  always_ff @(posedge clki) begin
    if (setup_byte && byte_cnt != 4'd8) setup_buf[byte_cnt[2:0]] <= rx_data;
  end

  // p1: registered request decode
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= !usb_rst && setup && rx_done && (byte_cnt == 4'd8);
  end

  always_ff @(posedge clki) begin
    if (setup && rx_done) begin
      dir_in_p1  <= setup_buf[0][7];
      req_p1     <= setup_buf[1];
      wvalue_p1  <= {setup_buf[3], setup_buf[2]};
      wlength_p1 <= {setup_buf[7], setup_buf[6]};
    end
  end

  always_comb begin
    dec_state = ST_STALL;
    dec_total = 16'd0;
    if (req_p1 == REQ_GET_DESCRIPTOR && dir_in_p1) begin
      if (wvalue_p1[15:8] == DESC_DEVICE) begin
        dec_state = ST_DATA_IN;
        dec_total = min16(wlength_p1, 16'(DEV_DESC_LEN));
      end else if (wvalue_p1[15:8] == DESC_CONFIG) begin
        dec_state = ST_DATA_IN;
        dec_total = min16(wlength_p1, 16'(CFG_DESC_LEN));
      end
    end else if ((req_p1 == REQ_SET_ADDRESS || req_p1 == REQ_SET_CONFIGURATION) && !dir_in_p1) begin
      dec_state = ST_STATUS_IN;
    end
  end

  // A full final packet that still falls short of wLength must be closed by a ZLP
  assign dec_zlp = (dec_total != 16'd0) && ((dec_total % 16'(MAX_PACKET)) == 16'd0) &&
                   (dec_total < wlength_p1);

  // p2: transfer state
  always_comb begin
    state_nxt = state;
    if (setup_byte || (setup && rx_done)) begin
      state_nxt = ST_IDLE;
    end else if (vld_p1) begin
      state_nxt = dec_state;
    end else begin
      case (state)
        ST_DATA_IN:    if (in_done && remaining == 16'd0 && !zlp_pend) state_nxt = ST_STATUS_OUT;
        ST_STATUS_OUT: if (rx_done && !setup) state_nxt = ST_IDLE;
        ST_STATUS_IN:  if (in_done) state_nxt = ST_IDLE;
        default:       state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)       state <= ST_IDLE;
    else if (usb_rst) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      handshake <= HS_ACK;   tx_valid  <= 1'b0;
      usb_addr  <= 7'd0;     cfg_value <= 8'd0;
      offset    <= 8'd0;     pkt_cnt   <= '0;
      remaining <= 16'd0;    zlp_pend  <= 1'b0;
      desc_type <= 8'd0;
    end else if (usb_rst) begin
      handshake <= HS_ACK;   tx_valid  <= 1'b0;
      usb_addr  <= 7'd0;     cfg_value <= 8'd0;
      offset    <= 8'd0;     pkt_cnt   <= '0;
      remaining <= 16'd0;    zlp_pend  <= 1'b0;
      desc_type <= 8'd0;
    end else begin
      handshake <= (state == ST_STALL) ? HS_STALL : HS_ACK;
      if (tx_req) tx_valid <= byte_ok;
      if (setup_byte) begin
        offset    <= 8'd0;
        pkt_cnt   <= '0;
        remaining <= 16'd0;
        zlp_pend  <= 1'b0;
      end else if (vld_p1) begin
        offset    <= 8'd0;
        pkt_cnt   <= '0;
        remaining <= dec_total;
        zlp_pend  <= dec_zlp;
        desc_type <= wvalue_p1[15:8];
      end else begin
        if (tx_req && byte_ok) begin
          offset    <= offset + 8'd1;
          pkt_cnt   <= pkt_cnt + PW'(1);
          remaining <= remaining - 16'd1;
        end
        if (in_done && state == ST_DATA_IN) begin
          pkt_cnt <= '0;
          if (remaining == 16'd0) zlp_pend <= 1'b0;
        end
        if (in_done && state == ST_STATUS_IN) begin
          if (req_p1 == REQ_SET_ADDRESS) usb_addr  <= wvalue_p1[6:0];
          else                           cfg_value <= wvalue_p1[7:0];
        end
      end
    end
  end

  usb_desc_rom u_rom (
    .clki      (clki),
    .rst_n     (rst_n),
    .clr       (usb_rst),
    .rd_en     (tx_req && byte_ok),
    .desc_type (desc_type),
    .offset    (offset),
    .data      (tx_data)
  );

endmodule
